// File: rtl/ascon_obi_arbiter_pkg.sv
// Shared types for the ASCON OBI arbiter: manager count, source-ID type and the OBI
// manager request/response structs used on the Croc crossbar.
package ascon_obi_arbiter_pkg;

  localparam int unsigned NumAsconMgr = 32'd5;

  typedef logic [$clog2(NumAsconMgr)-1:0] mgr_id_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [0:0]  aid;
  } mgr_obi_a_chan_t;

  typedef struct packed {
    mgr_obi_a_chan_t a;
    logic            req;
  } mgr_obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [0:0]  rid;
    logic        err;
  } mgr_obi_r_chan_t;

  typedef struct packed {
    logic            gnt;
    logic            rvalid;
    mgr_obi_r_chan_t r;
  } mgr_obi_rsp_t;

  // Increment an index modulo n.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
  endfunction

endpackage

// File: rtl/obi_arb_id_fifo.sv
// In-order FIFO of source IDs for outstanding OBI transactions.
// Depth must be a power of two so the pointers wrap naturally.
module obi_arb_id_fifo #(
  parameter int unsigned Depth = 32'd4,
  parameter int unsigned Width = 32'd3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_r [Depth];
  logic [PtrW-1:0]  wr_ptr_r;
  logic [PtrW-1:0]  rd_ptr_r;
  logic [PtrW:0]    count_r;

  assign data_o  = mem_r[rd_ptr_r];
  assign count_o = count_r;
  assign full_o  = (count_r == (PtrW+1)'(Depth));
  assign empty_o = (count_r == '0);

  // Storage, pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_i) begin
        mem_r[wr_ptr_r] <= data_i;
        wr_ptr_r        <= wr_ptr_r + PtrW'(1);
      end
      if (pop_i) begin
        rd_ptr_r <= rd_ptr_r + PtrW'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_r <= count_r + (PtrW+1)'(1);
        2'b01:   count_r <= count_r - (PtrW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/ascon_obi_arbiter.sv
// Round-robin arbiter sharing one crossbar OBI manager port between the ASCON DMA managers.
// Define OBI_ARB_PRIO_EN to give requester HiPrioIdx absolute priority on new arbitrations.
module ascon_obi_arbiter
  import ascon_obi_arbiter_pkg::*;
#(
  parameter int unsigned NumMgr         = NumAsconMgr,
  parameter int unsigned MaxOutstanding = 32'd4,
  parameter int unsigned HiPrioIdx      = 32'd3
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  mgr_obi_req_t [NumMgr-1:0] mgr_req_i,
  output mgr_obi_rsp_t [NumMgr-1:0] mgr_rsp_o,
  output mgr_obi_req_t              out_req_o,
  input  mgr_obi_rsp_t              out_rsp_i,
  output logic                      err_o
);

  localparam int unsigned IdW  = (NumMgr > 32'd1) ? $clog2(NumMgr) : 32'd1;
  localparam int unsigned CntW = $clog2(MaxOutstanding) + 32'd1;
`ifdef OBI_ARB_PRIO_EN
  localparam bit PrioEn = 1'b1;
`else
  localparam bit PrioEn = 1'b0;
`endif

  typedef logic [IdW-1:0] id_t;

  logic [NumMgr-1:0] eligible_s;
  logic              any_elig_s;
  logic              req_s;
  logic              hs_s;
  logic              push_s;
  logic              pop_s;
  logic              full_s;
  logic              empty_s;
  logic [CntW-1:0]   count_s;
  id_t               sel_s;
  id_t               head_s;
  id_t               sel_r;
  id_t               rr_ptr_r;
  logic              lock_r;
  logic              err_r;

  // Eligibility uses the registered count only, so a same-cycle pop never unblocks a push.
  always_comb begin
    eligible_s = '0;
    for (int i = 0; i < NumMgr; i++) begin
      eligible_s[i] = mgr_req_i[i].req & (count_s < CntW'(MaxOutstanding));
    end
  end

  assign any_elig_s = |eligible_s;
  assign req_s      = lock_r | any_elig_s;
  assign hs_s       = req_s & out_rsp_i.gnt;
  assign push_s     = hs_s & ~full_s;
  assign pop_s      = out_rsp_i.rvalid & ~empty_s;
  assign err_o      = err_r;

  // Winner selection; the scan runs downward so the nearest eligible index from rr_ptr wins.
  always_comb begin
    sel_s = rr_ptr_r;
    if (lock_r) begin
      sel_s = sel_r;
    end else if (PrioEn && eligible_s[HiPrioIdx]) begin
      sel_s = id_t'(HiPrioIdx);
    end else begin
      for (int k = NumMgr - 1; k >= 0; k--) begin
        sel_s = eligible_s[(int'(rr_ptr_r) + k) % NumMgr] ?
                id_t'((int'(rr_ptr_r) + k) % NumMgr) : sel_s;
      end
    end
  end

  // Forward the winning A channel and fan grant/response back out to the managers.
  always_comb begin
    out_req_o     = '0;
    out_req_o.req = req_s;
    if (req_s) begin
      out_req_o.a = mgr_req_i[sel_s].a;
    end else begin
      out_req_o.a = '0;
    end
    mgr_rsp_o = '0;
    for (int i = 0; i < NumMgr; i++) begin
      mgr_rsp_o[i].gnt = hs_s & (sel_s == id_t'(i));
      if (pop_s && (head_s == id_t'(i))) begin
        mgr_rsp_o[i].rvalid = 1'b1;
        mgr_rsp_o[i].r      = out_rsp_i.r;
      end else begin
        mgr_rsp_o[i].rvalid = 1'b0;
        mgr_rsp_o[i].r      = '0;
      end
    end
  end

  // Lock, round-robin pointer and sticky error for responses with nothing outstanding.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_r   <= 1'b0;
      sel_r    <= '0;
      rr_ptr_r <= '0;
      err_r    <= 1'b0;
    end else begin
      lock_r <= req_s & ~out_rsp_i.gnt;
      sel_r  <= sel_s;
      if (hs_s && !(PrioEn && (sel_s == id_t'(HiPrioIdx)))) begin
        rr_ptr_r <= id_t'(wrap_inc(32'(sel_s), NumMgr));
      end
      if (out_rsp_i.rvalid && empty_s) begin
        err_r <= 1'b1;
      end
    end
  end

  obi_arb_id_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdW)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_s),
    .data_i  (sel_s),
    .pop_i   (pop_s),
    .data_o  (head_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .count_o (count_s)
  );

endmodule

// File: tb/tb_ascon_obi_arbiter.sv
// Directed self-checking bench for ascon_obi_arbiter.
module tb_ascon_obi_arbiter;
  import ascon_obi_arbiter_pkg::*;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  mgr_obi_req_t [4:0]  mgr_req;
  mgr_obi_rsp_t [4:0]  mgr_rsp;
  mgr_obi_req_t        out_req;
  mgr_obi_rsp_t        out_rsp;
  logic                err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  ascon_obi_arbiter dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .mgr_req_i (mgr_req),
    .mgr_rsp_o (mgr_rsp),
    .out_req_o (out_req),
    .out_rsp_i (out_rsp),
    .err_o     (err)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [4:0] gnt_vec();
    logic [4:0] v;
    for (int i = 0; i < 5; i++) v[i] = mgr_rsp[i].gnt;
    return v;
  endfunction

  function automatic logic [4:0] rvalid_vec();
    logic [4:0] v;
    for (int i = 0; i < 5; i++) v[i] = mgr_rsp[i].rvalid;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    mgr_req = '0;
    out_rsp = '0;
    rst_ni  = 1'b0;
    tick();
    rst_ni  = 1'b1;
  endtask

  initial begin
    int grants;
    int idx;

    // Reset state
    mgr_req = '0;
    out_rsp = '0;
    rst_ni  = 1'b0;
    #2;
    check_eq("rst_out_req", out_req, '0);
    check_eq("rst_gnt", gnt_vec(), 5'b00000);
    check_eq("rst_rvalid", rvalid_vec(), 5'b00000);
    check_eq("rst_err", err, 1'b0);
    tick();
    rst_ni = 1'b1;
    tick();

    // Single requester: mgr 2 read, response two cycles later
    mgr_req[2].req    = 1'b1;
    mgr_req[2].a.addr = 32'h0000_1000;
    mgr_req[2].a.aid  = 1'b1;
    out_rsp.gnt       = 1'b1;
    #1;
    check_eq("single_req", out_req.req, 1'b1);
    check_eq("single_addr", out_req.a.addr, 32'h0000_1000);
    check_eq("single_aid", out_req.a.aid, 1'b1);
    check_eq("single_gnt", gnt_vec(), 5'b00100);
    tick();
    mgr_req = '0;
    tick();
    out_rsp.rvalid  = 1'b1;
    out_rsp.r.rdata = 32'hCAFE_F00D;
    #1;
    check_eq("single_rvalid", rvalid_vec(), 5'b00100);
    check_eq("single_rdata", mgr_rsp[2].r.rdata, 32'hCAFE_F00D);
    check_eq("single_other_r", mgr_rsp[0].r.rdata, 32'h0);
    tick();
    out_rsp = '0;
    #1;
    check_eq("single_err", err, 1'b0);

    // All five requesting with gnt always high, one response per cycle
    do_reset();
    for (int k = 0; k < 7; k++) begin
      for (int i = 0; i < 5; i++) begin
        mgr_req[i].req    = (k < 6);
        mgr_req[i].a.addr = 32'h4000_0000 + 32'(i * 4);
      end
      out_rsp.gnt     = 1'b1;
      out_rsp.rvalid  = (k >= 1);
      out_rsp.r.rdata = 32'h100 + 32'(k);
      #1;
      check_eq("rr_gnt", gnt_vec(), (k < 6) ? (64'd1 << (k % 5)) : 64'd0);
      if (k < 6) begin
        check_eq("rr_addr", out_req.a.addr, 32'h4000_0000 + 32'((k % 5) * 4));
      end
      if (k >= 1) begin
        idx = (k - 1) % 5;
        check_eq("rr_rvalid", rvalid_vec(), 64'd1 << idx);
        check_eq("rr_rdata", mgr_rsp[idx].r.rdata, 32'h100 + 32'(k));
      end
      tick();
    end

    // Lock: mgr 1 selected, gnt held low while mgr 0 joins
    do_reset();
    mgr_req[1].req    = 1'b1;
    mgr_req[1].a.addr = 32'h2000_0010;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin
        mgr_req[0].req    = 1'b1;
        mgr_req[0].a.addr = 32'h3000_0000;
      end
      #1;
      check_eq("lock_addr", out_req.a.addr, 32'h2000_0010);
      check_eq("lock_no_gnt", gnt_vec(), 5'b00000);
      tick();
    end
    out_rsp.gnt = 1'b1;
    #1;
    check_eq("lock_gnt1", gnt_vec(), 5'b00010);
    tick();
    mgr_req[1].req = 1'b0;
    #1;
    check_eq("lock_gnt0", gnt_vec(), 5'b00001);
    check_eq("lock_addr0", out_req.a.addr, 32'h3000_0000);
    tick();

    // Full FIFO: six grant attempts, only four succeed
    do_reset();
    mgr_req[0].req    = 1'b1;
    mgr_req[0].a.addr = 32'h5000;
    mgr_req[1].req    = 1'b1;
    mgr_req[1].a.addr = 32'h5004;
    out_rsp.gnt       = 1'b1;
    grants            = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (gnt_vec() != 5'b00000) grants++;
      if (k >= 4) check_eq("full_req_low", out_req.req, 1'b0);
      tick();
    end
    check_eq("full_grants", grants, 4);
    out_rsp.rvalid  = 1'b1;
    out_rsp.r.rdata = 32'h77;
    #1;
    check_eq("full_pop_req", out_req.req, 1'b0);
    check_eq("full_pop_rvalid", rvalid_vec(), 5'b00001);
    tick();
    out_rsp.rvalid = 1'b0;
    #1;
    check_eq("full_regrant", gnt_vec(), 5'b00001);
    tick();

    // rvalid with nothing outstanding
    do_reset();
    out_rsp.rvalid  = 1'b1;
    out_rsp.r.rdata = 32'hDEAD_BEEF;
    #1;
    check_eq("empty_rvalid", rvalid_vec(), 5'b00000);
    tick();
    out_rsp.rvalid = 1'b0;
    #1;
    check_eq("empty_err_set", err, 1'b1);
    tick();
    tick();
    check_eq("empty_err_hold", err, 1'b1);
    rst_ni = 1'b0;
    #1;
    check_eq("empty_err_clr", err, 1'b0);
    tick();
    rst_ni = 1'b1;

    // Priority: mgr 3 and mgr 0 together with rr_ptr = 0
    do_reset();
    mgr_req[0].req = 1'b1;
    mgr_req[3].req = 1'b1;
    out_rsp.gnt    = 1'b1;
    #1;
`ifdef OBI_ARB_PRIO_EN
    check_eq("prio_first", gnt_vec(), 5'b01000);
`else
    check_eq("prio_first", gnt_vec(), 5'b00001);
`endif
    tick();
    check_eq("prio_second", gnt_vec(), 5'b01000);
    tick();
    mgr_req = '0;
    out_rsp = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
